// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e : FSM state encoding (3 bits)
//   PAR_EVEN / PAR_ODD : meaning of the PAR_TYP input
//   exp_parity : parity bit the transmitter should have sent for a given
//                data-reduction XOR and parity type
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // data_xor is the XOR of all data bits; odd parity inverts it.
    function automatic logic exp_parity(input logic data_xor, input logic par_typ);
        logic res;
        case (par_typ)
            PAR_EVEN: res = data_xor;
            PAR_ODD:  res = ~data_xor;
            default:  res = data_xor;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receiver.
// Ports:
//   CLK, RST     : clock, asynchronous active-low reset
//   enable_i     : count edges (frame in progress); edge count held at 0 otherwise
//   clear_i      : clear the data-bit counter
//   bit_inc_i    : advance the data-bit counter
//   prescale_i   : latched oversampling ratio; edge count wraps after prescale_i-1
//   edge_cnt_o   : oversample edge index within the current bit
//   last_o       : edge_cnt_o is the final edge of the bit
//   bit_cnt_o    : number of data bits received so far
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic                      bit_inc_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
    output logic                      last_o,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q;

    // An unsupported ratio of 0 makes this compare against all-ones, so the
    // counter still wraps naturally and the frame always terminates.
    assign last_o     = (edge_cnt_q == (prescale_i - PRESCALE_WIDTH'(1)));
    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;

    // Edge counter: held at zero while idle, wraps after the last edge of a bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
        end else if (!enable_i) begin
            edge_cnt_q <= '0;
        end else if (last_o) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    // Data-bit counter: cleared while idle, advanced once per received data bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_q <= '0;
        end else if (clear_i) begin
            bit_cnt_q <= '0;
        end else if (bit_inc_i) begin
            bit_cnt_q <= bit_cnt_q + BIT_CNT_WIDTH'(1);
        end else begin
            bit_cnt_q <= bit_cnt_q;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller. Tracks start/data/parity/stop bits, strobes
// the deserializer, and reports each frame as good (data_valid) or bad
// (par_err / stp_err). Start-bit glitches are dropped silently.
// Ports:
//   CLK, RST     : clock, asynchronous active-low reset
//   RX_IN        : synchronized serial line, idle high
//   Prescale     : oversampling ratio (8/16/32), latched at frame start
//   PAR_EN       : frame carries a parity bit, latched at frame start
//   PAR_TYP      : 0 even / 1 odd parity, latched at frame start
//   sampled_bit  : majority-voted bit from the sampler
//   P_DATA       : deserializer contents
//   dat_samp_en  : sampler enable (frame in progress)
//   edge_cnt     : oversample edge index within the current bit
//   deser_en     : deserializer shift strobe (last edge of a data bit)
//   data_valid   : one-cycle pulse, P_DATA holds a good frame
//   par_err      : one-cycle pulse, parity mismatch
//   stp_err      : one-cycle pulse, stop bit sampled low
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled_bit,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      dat_samp_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      deser_en,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int                      BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT     = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    rx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic                      idle_s;
    logic                      last_s;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_s;

    assign idle_s = (state_q == ST_IDLE);

    uart_rx_edge_bit_counter #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .enable_i   (!idle_s),
        .clear_i    (idle_s),
        .bit_inc_i  (deser_en),
        .prescale_i (prescale_q),
        .edge_cnt_o (edge_cnt),
        .last_o     (last_s),
        .bit_cnt_o  (bit_cnt_s)
    );

    assign dat_samp_en = !idle_s;
    assign deser_en    = (state_q == ST_DATA) && last_s;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

    // State, latched frame configuration and result pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    // Next-state decode; every bit decision is taken on the last edge of the bit.
    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d    = ST_START;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_s) begin
                    // A start bit that reads back high was line noise.
                    if (!sampled_bit) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (last_s && (bit_cnt_s == LAST_BIT)) begin
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (last_s) begin
                    if (sampled_bit != exp_parity(^P_DATA, par_typ_q)) begin
                        par_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (last_s) begin
                    if (sampled_bit) begin
                        data_valid_d = 1'b1;
                    end else begin
                        stp_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
